dmem_arbiter: RTL

- Shares the CPU's single data-memory port (cmd_memory / addr_memory / data_memory bus) between two requesters.
- Requester 0 is the control unit's load/store path; requester 1 is a secondary master (program loader / debug / IO).
- Sequences each access with a req/ack handshake, round-robin arbitration, a configurable read latency and tri-state ownership of data_memory.
- Sits between the control unit and the memory interface.

---
 rtl/dmem_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the CPU's single data-memory port between two requesters:
//   requester 0 - control unit load/store path
//   requester 1 - secondary master (program loader / debug / IO)
//
// Each access is a req/ack handshake. Arbitration is round-robin on ties.
// Writes drive data_memory for exactly one cycle. Reads hold cmd_memory at
// CMD_RD for READ_LAT cycles and then sample the bus. Every access ends with
// a one-cycle ACK, followed by at least one IDLE cycle. That IDLE cycle
// doubles as bus turnaround.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   m0_req/m1_req     access request (held until ack)
//   m0_we/m1_we       1 = write, 0 = read
//   m0_addr/m1_addr   access address
//   m0_wdata/m1_wdata write data
//   m0_rdata/m1_rdata read data, held until that requester's next read
//   m0_ack/m1_ack     one-cycle completion pulse
//   cmd_memory        command to the memory interface (IDLE/RD/WR)
//   addr_memory       address to the memory interface
//   data_memory       bidirectional data bus, driven only while writing
//   busy              arbiter not idle
//   owner             index of current grant (meaningful while busy)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int         READ_LAT = 1,
    parameter logic [7:0] CMD_IDLE = 8'h00,
    parameter logic [7:0] CMD_RD   = 8'h01,
    parameter logic [7:0] CMD_WR   = 8'h02
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       m0_req,
    input  logic       m0_we,
    input  logic [7:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic [7:0] m0_rdata,
    output logic       m0_ack,

    input  logic       m1_req,
    input  logic       m1_we,
    input  logic [7:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic [7:0] m1_rdata,
    output logic       m1_ack,

    output logic [7:0] cmd_memory,
    output logic [7:0] addr_memory,
    inout  wire  [7:0] data_memory,
    output logic       busy,
    output logic       owner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE_WR,
        S_READ,
        S_ACK
    } state_t;

    // Counter reload: the READ state is left when the counter reaches zero,
    // so loading READ_LAT-1 yields exactly READ_LAT cycles of CMD_RD.
    localparam logic [2:0] RD_CNT_INIT = 3'(READ_LAT - 1);

    state_t     state;
    state_t     state_nxt;

    logic       last;
    logic [2:0] rd_cnt;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;

    logic       grant_vld;
    logic       grant_idx;
    logic       grant_we;
    logic [7:0] grant_addr;
    logic [7:0] grant_wdata;
    logic       drive_en;

    // -------------------------------------------------------------------------
    // Request selection. On a tie the requester that did not win last time is
    // chosen; reset leaves last=1 so requester 0 wins the first tie.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_vld = m0_req | m1_req;
        if (m0_req && m1_req) begin
            grant_idx = ~last;
        end else begin
            grant_idx = m1_req;
        end
        grant_we    = grant_idx ? m1_we    : m0_we;
        grant_addr  = grant_idx ? m1_addr  : m0_addr;
        grant_wdata = grant_idx ? m1_wdata : m0_wdata;
    end

    // -------------------------------------------------------------------------
    // State register. The bus-facing outputs are decoded from this register,
    // so an asynchronous reset returns them to idle without a clock edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and state-decoded outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        cmd_memory = CMD_IDLE;
        drive_en   = 1'b0;
        busy       = 1'b1;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;

        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (grant_vld) begin
                    state_nxt = grant_we ? S_ISSUE_WR : S_READ;
                end
            end

            S_ISSUE_WR: begin
                cmd_memory = CMD_WR;
                drive_en   = 1'b1;
                state_nxt  = S_ACK;
            end

            S_READ: begin
                cmd_memory = CMD_RD;
                if (rd_cnt == 3'd0) begin
                    state_nxt = S_ACK;
                end
            end

            S_ACK: begin
                m0_ack    = ~owner;
                m1_ack    = owner;
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Access registers. The address, write data and owner are captured at
    // grant time, so the requester's inputs may change once the access has
    // started without disturbing it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            owner    <= 1'b0;
            last     <= 1'b1;
            rd_cnt   <= 3'd0;
            m0_rdata <= 8'h00;
            m1_rdata <= 8'h00;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        owner   <= grant_idx;
                        last    <= grant_idx;
                        addr_q  <= grant_addr;
                        wdata_q <= grant_wdata;
                        rd_cnt  <= RD_CNT_INIT;
                    end
                end

                S_READ: begin
                    // The edge that ends the final READ cycle samples the bus.
                    if (rd_cnt == 3'd0) begin
                        if (owner) begin
                            m1_rdata <= data_memory;
                        end else begin
                            m0_rdata <= data_memory;
                        end
                    end else begin
                        rd_cnt <= rd_cnt - 3'd1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // addr_memory keeps the last granted address through ACK and IDLE.
    assign addr_memory = addr_q;

    // The bus is released in every state except ISSUE_WR, including reset.
    assign data_memory = drive_en ? wdata_q : 8'hzz;

endmodule
